// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter between the core (port A) and the bulk
// loader/clear engine (port B) in front of the single-port data memory.
// A port may hold the grant for a bounded burst with its lock input. Read
// data comes back registered, one cycle after the grant.
module dm_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    // Port encoding throughout: 0 = A, 1 = B.
    logic          last, last_nxt;
    logic          owner_locked, locked_nxt;
    logic          owner, owner_nxt;
    logic [CW-1:0] burst_cnt, cnt_nxt;

    logic any_req;
    logic win_b;
    logic win_we;
    logic win_lock;

    assign any_req = a_req | b_req;

    // Winner selection: a single requester always wins; on a tie the locked
    // owner keeps the grant until its burst budget is spent, otherwise the
    // port that did not win last time takes it.
    always_comb begin
        win_b = b_req;
        if (a_req && b_req) begin
            if (owner_locked && (burst_cnt < MAX_CNT)) begin
                win_b = owner;
            end else if (owner_locked) begin
                win_b = ~owner;
            end else begin
                win_b = ~last;
            end
        end
    end

    assign a_gnt    = any_req & ~win_b;
    assign b_gnt    = any_req & win_b;
    assign win_we   = win_b ? b_we : a_we;
    assign win_lock = win_b ? b_lock : a_lock;

    // Memory bus follows the winner; parked at zero when idle. Writes are
    // suppressed while reset is asserted even though arbitration still runs.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (a_gnt) begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_we    = a_we & rst_n;
        end else if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_we    = b_we & rst_n;
        end
    end

    // Next arbitration state: the winner's lock decides whether a burst
    // starts or continues; an idle cycle means the owner dropped its request.
    always_comb begin
        last_nxt   = last;
        locked_nxt = owner_locked;
        owner_nxt  = owner;
        cnt_nxt    = burst_cnt;
        if (any_req) begin
            last_nxt = win_b;
            if (win_lock) begin
                locked_nxt = 1'b1;
                owner_nxt  = win_b;
                if (owner_locked && (owner == win_b)) begin
                    cnt_nxt = (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + CW'(1);
                end else begin
                    cnt_nxt = CW'(1);
                end
            end else begin
                locked_nxt = 1'b0;
                cnt_nxt    = '0;
            end
        end else begin
            locked_nxt = 1'b0;
            cnt_nxt    = '0;
        end
    end

    // Arbitration state register; reset makes A win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last         <= 1'b1;
            owner_locked <= 1'b0;
            owner        <= 1'b0;
            burst_cnt    <= '0;
        end else begin
            last         <= last_nxt;
            owner_locked <= locked_nxt;
            owner        <= owner_nxt;
            burst_cnt    <= cnt_nxt;
        end
    end

    // Registered read return; rdata holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (a_gnt && !a_we) begin
                a_rdata <= mem_rdata;
            end
            if (b_gnt && !b_we) begin
                b_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vectors with hand-computed grant patterns.
// Stimulus pushes expected grants and read data into queues; a monitor on the
// falling edge pops and compares them.
module tb_dm_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] gnt_q[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] ref_mem[256];
    logic [7:0] mem[256];
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 7) ^ 8'hA5;
    endfunction

    // Behavioural single-port memory with combinational read.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: grants of the current cycle and read returns of the previous one.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (gnt_q.size() > 0) chk("gnt", {30'd0, a_gnt, b_gnt}, {30'd0, gnt_q.pop_front()});
            if (a_rvalid) begin
                if (exp_a.size() == 0) chk("a_rvalid_unexpected", 1, 0);
                else begin e = exp_a.pop_front(); chk("a_rdata", a_rdata, e); end
            end
            if (b_rvalid) begin
                if (exp_b.size() == 0) chk("b_rvalid_unexpected", 1, 0);
                else begin e = exp_b.pop_front(); chk("b_rdata", b_rdata, e); end
            end
        end
    end

    // One cycle of stimulus; eg is the hand-computed {a_gnt, b_gnt}.
    task automatic step(input logic ar, input logic aw, input logic al, input logic [7:0] aa,
                        input logic [7:0] ad, input logic br, input logic bw, input logic bl,
                        input logic [7:0] ba, input logic [7:0] bd, input logic [1:0] eg);
        a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
        gnt_q.push_back(eg);
        if (eg == 2'b10) begin
            if (aw) ref_mem[aa] = ad; else exp_a.push_back(ref_mem[aa]);
        end else if (eg == 2'b01) begin
            if (bw) ref_mem[ba] = bd; else exp_b.push_back(ref_mem[ba]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rst_n = 1'b0;
        a_req = 1; a_we = 1; a_lock = 0; a_addr = 8'h11; a_wdata = 8'hEE;
        b_req = 1; b_we = 1; b_lock = 0; b_addr = 8'h22; b_wdata = 8'hDD;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_gnt", a_gnt, 1);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 8'h11);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        mem_ready = 1'b1;
        a_req = 0; b_req = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read-back on A.
        step(1, 1, 0, 8'd31, 8'h5A, 0, 0, 0, 8'd0, 8'd0, 2'b10);
        step(1, 0, 0, 8'd31, 8'h00, 0, 0, 0, 8'd0, 8'd0, 2'b10);

        // Both reading, no lock: last = A, so B, A, B, A ...
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 8'(40 + k), 8'd0, 1, 0, 0, 8'(20 + k), 8'd0, 2'b01);
            step(1, 0, 0, 8'(40 + k), 8'd0, 1, 0, 0, 8'(21 + k), 8'd0, 2'b10);
        end

        // B clears with lock while A reads: B x4, A x1, repeating.
        begin
            int ba = 0;
            int aa = 1;
            for (int i = 0; i < 10; i++) begin
                if (i % 5 == 4) begin
                    step(1, 0, 0, 8'(aa), 8'd0, 1, 1, 1, 8'(ba), 8'h00, 2'b10);
                    aa = aa + 4;
                end else begin
                    step(1, 0, 0, 8'(aa), 8'd0, 1, 1, 1, 8'(ba), 8'h00, 2'b01);
                    ba = ba + 1;
                end
            end
        end

        // B alone, locked, 10 writes: counter saturates, A then wins at once.
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 8'd0, 8'd0, 1, 1, 1, 8'(100 + i), 8'(8'h30 + i), 2'b01);
        step(1, 0, 0, 8'd100, 8'd0, 1, 1, 1, 8'd110, 8'h3A, 2'b10);
        step(0, 0, 0, 8'd0, 8'd0, 1, 1, 1, 8'd110, 8'h3A, 2'b01);

        // B writes addr 3, A reads it the next cycle.
        step(0, 0, 0, 8'd0, 8'd0, 1, 1, 0, 8'd3, 8'hC3, 2'b01);
        step(1, 0, 0, 8'd3, 8'd0, 0, 0, 0, 8'd0, 8'd0, 2'b10);

        // B reads the value it just wrote back.
        step(0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 8'd110, 8'd0, 2'b01);

        // Idle bus is parked at zero.
        a_req = 0; a_we = 1; a_addr = 8'h55; a_wdata = 8'h66;
        b_req = 0; b_we = 1; b_addr = 8'h77; b_wdata = 8'h88;
        gnt_q.push_back(2'b00);
        #1;
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_wdata", mem_wdata, 0);
        chk("idle_mem_we", mem_we, 0);
        @(posedge clk); #1;

        // Read addr 7 on A, then reset pulsed before rvalid is sampled.
        a_req = 1; a_we = 0; a_lock = 0; a_addr = 8'd7;
        gnt_q.push_back(2'b10);
        @(posedge clk); #1;
        chk("pre_rst_a_rvalid", a_rvalid, 1);
        chk("pre_rst_a_rdata", a_rdata, ref_mem[7]);
        a_req = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_a_rvalid", a_rvalid, 0);
        a_req = 1; b_req = 1; a_we = 0; b_we = 0;
        #1;
        chk("rst2_a_gnt", a_gnt, 1);
        chk("rst2_b_gnt", b_gnt, 0);
        a_req = 0; b_req = 0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        step(1, 0, 0, 8'd8, 8'd0, 1, 0, 0, 8'd9, 8'd0, 2'b10);
        step(0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 8'd9, 8'd0, 2'b01);
        step(0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0, 8'd0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("gnt_q_drained", gnt_q.size(), 0);
        chk("exp_a_drained", exp_a.size(), 0);
        chk("exp_b_drained", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter in front of the single-port data memory. The processor core (port A) and a bulk loader/clear engine (port B) share the memory through it. It grants at most one access per cycle under round-robin, with an optional bounded lock for back-to-back bursts. It also returns registered read data with a valid strobe to the winning requester.

## Interface
- AW, 8, address width (256-entry memory)
- DW, 8, data width
- MAX_BURST, 4, maximum consecutive locked grants to one port while the other port is requesting (≥1)

- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  reset, asynchronous, active-low (0 = reset)
- a_req / b_req  in  1  access request; held, with its fields stable, until the matching gnt is high
- a_we / b_we  in  1  1 = write, 0 = read
- a_lock / b_lock  in  1  ask to keep the grant next cycle (burst)
- a_addr / b_addr  in  AW  address
- a_wdata / b_wdata  in  DW  write data
- a_gnt / b_gnt  out  1  access performed this cycle (combinational)
- a_rvalid / b_rvalid  out  1  read data valid (registered)
- a_rdata / b_rdata  out  DW  read data (registered)
- mem_addr  out  AW  to the data memory
- mem_we  out  1  to the data memory; write is committed on the rising edge
- mem_wdata  out  DW  to the data memory
- mem_rdata  in  DW  combinational read data from the data memory

## Operation
- State:
  - `last` (1 bit): last winner, A = 0, B = 1.
  - `owner_locked` (1 bit) plus `owner` (1 bit): the locked owner.
  - `burst_cnt` (range 0..MAX_BURST).
- Winner selection, evaluated each cycle:
  - Only one port requesting: that port wins.
  - Both requesting, no active lock: the port ≠ `last` wins.
  - Both requesting, lock active on `owner`, and burst_cnt < MAX_BURST: `owner` wins.
  - Both requesting, lock active, and burst_cnt = MAX_BURST: the non-owner wins and the lock is cleared.
- Exactly one gnt is high when any req is high. Neither gnt is high when no req is high.
- Memory bus is driven from the winner's fields. When idle: mem_we = 0, mem_addr/mem_wdata = 0.
- On a granted cycle:
  - `last` ← winner.
  - A read by the winner sets that port's rvalid = 1 and rdata ← mem_rdata on the next edge.
  - Every other rvalid is 0 that cycle.
  - A write produces no rvalid.
- Lock handling:
  - Winner's lock = 1: owner_locked ← 1, owner ← winner, burst_cnt ← (same owner ? burst_cnt+1 : 1).
  - Winner's lock = 0: owner_locked ← 0, burst_cnt ← 0.
  - Owner drops req: the lock clears on that cycle's edge.
- burst_cnt only limits the owner when the other port is requesting. With no contention it saturates at MAX_BURST.
- rdata holds its last value when rvalid = 0.

## Timing
- Reset (Reset = 0, asynchronous): last = 1 (A wins the first tie), owner_locked = 0, owner = 0, burst_cnt = 0, a/b_rvalid = 0, a/b_rdata = 0.
- gnt and mem_* outputs are combinational from req and state, so they are also defined during reset. Arbitration during reset still uses the reset state, but no memory write occurs while Reset = 0: mem_we is forced to 0.
- Latencies:
  - Grant latency is 0 cycles when uncontended.
  - Worst case under contention is MAX_BURST cycles.
  - Read latency is 1 cycle: gnt in cycle N, rvalid/rdata in N+1.
  - A write is visible to a read from either port in N+1.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset deasserting mid-burst gives no carry-over: the first cycle after reset uses the reset state.
- Reset asserting while rvalid = 1 clears rvalid immediately.

## Test plan
- Reset = 0 with a_req = b_req = 1 → a_gnt = 1, b_gnt = 0, mem_we = 0, a/b_rvalid = 0. Release reset; A writes 0x5A to addr 31 → the next-cycle A read of addr 31 gives a_rvalid = 1, a_rdata = 0x5A.
- Both ports continuously request reads, no lock → grants alternate A, B, A, B. Each rvalid appears one cycle after its gnt with the correct per-address data.
- B writes 0x00 to addrs 0..255 with b_lock = 1 while A requests, MAX_BURST = 4 → B receives 4 grants, then A receives 1, repeating. A is never starved for more than 4 cycles.
- B alone, lock = 1, 10 consecutive writes → b_gnt high for all 10 cycles. burst_cnt saturates at 4 and the first A request gets the grant within 1 cycle.
- A read of addr 7 on port A granted in cycle N, then Reset pulsed low mid-cycle N+1 → a_rvalid drops to 0 asynchronously. After release, a fresh tie is won by A.
- Write by B to addr 3 followed by a read from A of addr 3 in the next cycle → a_rdata equals B's written value.
